// File: rtl/biquad_sequencer.sv
// Sequencer and state registers for one second-order IIR section.
// Walks five MAC steps per sample and captures each datapath result.
module biquad_sequencer #(
    parameter int unsigned N = 24,
    parameter int unsigned F = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         clear,
    input  logic [N-1:0] u_in,
    input  logic [N-1:0] mac_res,
    output logic [2:0]   controlS,
    output logic [1:0]   controlC,
    output logic [2:0]   controlZ,
    output logic [N-1:0] Uk,
    output logic [N-1:0] fk,
    output logic [N-1:0] fk1,
    output logic [N-1:0] fk2,
    output logic [N-1:0] yk,
    output logic [N-1:0] acum1,
    output logic [N-1:0] acum2,
    output logic [N-1:0] acum3,
    output logic         busy,
    output logic         done
);

    // Coefficients are F+2 bits sign-extended into the N-bit word.
    if (F + 2 > N) begin : g_bad_width
        $error("biquad_sequencer: F+2 must not exceed N");
    end

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S1   = 3'd1;
    localparam logic [2:0] S2   = 3'd2;
    localparam logic [2:0] S3   = 3'd3;
    localparam logic [2:0] S4   = 3'd4;
    localparam logic [2:0] S5   = 3'd5;
    localparam logic [2:0] UPD  = 3'd6;

    logic [2:0]   state_q, state_d;
    logic [N-1:0] uk_q, uk_d;
    logic [N-1:0] fk_q, fk_d;
    logic [N-1:0] fk1_q, fk1_d;
    logic [N-1:0] fk2_q, fk2_d;
    logic [N-1:0] yk_q, yk_d;
    logic [N-1:0] acum1_q, acum1_d;
    logic [N-1:0] acum2_q, acum2_d;
    logic [N-1:0] acum3_q, acum3_d;

    always_comb begin
        state_d = state_q;
        uk_d    = uk_q;
        fk_d    = fk_q;
        fk1_d   = fk1_q;
        fk2_d   = fk2_q;
        yk_d    = yk_q;
        acum1_d = acum1_q;
        acum2_d = acum2_q;
        acum3_d = acum3_q;
        unique case (state_q)
            IDLE: begin
                // start takes priority; a simultaneous clear is dropped
                if (start) begin
                    uk_d    = u_in;
                    state_d = S1;
                end else if (clear) begin
                    fk_d  = '0;
                    fk1_d = '0;
                    fk2_d = '0;
                end
            end
            S1: begin
                acum1_d = mac_res;
                state_d = S2;
            end
            S2: begin
                fk_d    = mac_res;
                state_d = S3;
            end
            S3: begin
                acum2_d = mac_res;
                state_d = S4;
            end
            S4: begin
                acum3_d = mac_res;
                state_d = S5;
            end
            S5: begin
                yk_d    = mac_res;
                state_d = UPD;
            end
            UPD: begin
                fk2_d   = fk1_q;
                fk1_d   = fk_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            uk_q    <= '0;
            fk_q    <= '0;
            fk1_q   <= '0;
            fk2_q   <= '0;
            yk_q    <= '0;
            acum1_q <= '0;
            acum2_q <= '0;
            acum3_q <= '0;
        end else begin
            state_q <= state_d;
            uk_q    <= uk_d;
            fk_q    <= fk_d;
            fk1_q   <= fk1_d;
            fk2_q   <= fk2_d;
            yk_q    <= yk_d;
            acum1_q <= acum1_d;
            acum2_q <= acum2_d;
            acum3_q <= acum3_d;
        end
    end

    // Select codes are a pure function of the state register.
    always_comb begin
        controlS = 3'b000;
        controlC = 2'b00;
        controlZ = 3'b000;
        unique case (state_q)
            S1:  begin controlS = 3'b001; controlC = 2'b01; controlZ = 3'b001; end
            S2:  begin controlS = 3'b010; controlC = 2'b10; controlZ = 3'b011; end
            S3:  begin controlS = 3'b011; controlC = 2'b11; controlZ = 3'b000; end
            S4:  begin controlS = 3'b100; controlC = 2'b01; controlZ = 3'b100; end
            S5:  begin controlS = 3'b101; controlC = 2'b10; controlZ = 3'b101; end
            UPD: begin controlS = 3'b000; controlC = 2'b00; controlZ = 3'b010; end
            default: begin
                controlS = 3'b000;
                controlC = 2'b00;
                controlZ = 3'b000;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == UPD);
    assign Uk    = uk_q;
    assign fk    = fk_q;
    assign fk1   = fk1_q;
    assign fk2   = fk2_q;
    assign yk    = yk_q;
    assign acum1 = acum1_q;
    assign acum2 = acum2_q;
    assign acum3 = acum3_q;

endmodule

// File: tb/tb_biquad_sequencer.sv
// Bench for biquad_sequencer: scripted and closed-loop MAC, transaction-level model.
module tb_biquad_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, clear;
    logic [23:0] u_in, mac_res;
    logic [2:0]  controlS, controlZ;
    logic [1:0]  controlC;
    logic [23:0] Uk, fk, fk1, fk2, yk, acum1, acum2, acum3;
    logic        busy, done;

    biquad_sequencer #(.N(24), .F(15)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .u_in(u_in),
        .mac_res(mac_res), .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
        .Uk(Uk), .fk(fk), .fk1(fk1), .fk2(fk2), .yk(yk), .acum1(acum1), .acum2(acum2),
        .acum3(acum3), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [23:0] mac_tab [0:7];
    bit          closed = 1'b0;
    longint      ka1, ka2, kb0, kb1, kb2;

    // Transaction-level model of the visible words
    logic [23:0] m_uk, m_fk, m_fk1, m_fk2, m_yk, m_a1, m_a2, m_a3;

    function automatic longint sx24(input longint v);
        logic [23:0] t;
        t = v[23:0];
        return longint'($signed(t));
    endfunction

    function automatic longint sx17(input logic [31:0] v);
        logic [16:0] t;
        t = v[16:0];
        return longint'($signed(t));
    endfunction

    // Bench-side datapath: scripted per-step values or a real Q15 MAC
    longint zv, cv, kv;
    always_comb begin
        zv = 0;
        cv = 0;
        kv = 0;
        mac_res = '0;
        if (closed) begin
            case (controlZ)
                3'd1: zv = sx24(longint'(Uk));
                3'd2: zv = sx24(longint'(yk));
                3'd3: zv = sx24(longint'(acum1));
                3'd4: zv = sx24(longint'(acum2));
                3'd5: zv = sx24(longint'(acum3));
                default: zv = 0;
            endcase
            case (controlC)
                2'd1: cv = sx24(longint'(fk1));
                2'd2: cv = sx24(longint'(fk2));
                2'd3: cv = sx24(longint'(fk));
                default: cv = 0;
            endcase
            case (controlS)
                3'd1: kv = ka1;
                3'd2: kv = ka2;
                3'd3: kv = kb0;
                3'd4: kv = kb1;
                3'd5: kv = kb2;
                default: kv = 0;
            endcase
            mac_res = 24'(zv + ((kv * cv) >>> 15));
        end else begin
            mac_res = mac_tab[controlS];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_uk = 0; m_fk = 0; m_fk1 = 0; m_fk2 = 0;
        m_yk = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0;
    endtask

    task automatic model_req(input logic [23:0] u);
        m_uk  = u;
        m_a1  = mac_tab[1];
        m_fk  = mac_tab[2];
        m_a2  = mac_tab[3];
        m_a3  = mac_tab[4];
        m_yk  = mac_tab[5];
        m_fk2 = m_fk1;
        m_fk1 = mac_tab[2];
    endtask

    task automatic check_words(input string tag);
        check_eq({tag, ".Uk"},    Uk,    m_uk);
        check_eq({tag, ".fk"},    fk,    m_fk);
        check_eq({tag, ".fk1"},   fk1,   m_fk1);
        check_eq({tag, ".fk2"},   fk2,   m_fk2);
        check_eq({tag, ".yk"},    yk,    m_yk);
        check_eq({tag, ".acum1"}, acum1, m_a1);
        check_eq({tag, ".acum2"}, acum2, m_a2);
        check_eq({tag, ".acum3"}, acum3, m_a3);
    endtask

    task automatic check_idle_out(input string tag);
        check_eq({tag, ".S"},    controlS, 0);
        check_eq({tag, ".C"},    controlC, 0);
        check_eq({tag, ".Z"},    controlZ, 0);
        check_eq({tag, ".busy"}, busy,     0);
        check_eq({tag, ".done"}, done,     0);
    endtask

    // One request from IDLE; checks select sequence and done timing
    task automatic run_req(input logic [23:0] u, input logic clr, input bit scripted);
        logic [1:0] exp_c [1:5];
        logic [2:0] exp_z [1:5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        exp_z = '{3'd1, 3'd3, 3'd0, 3'd4, 3'd5};
        start = 1'b1;
        clear = clr;
        u_in  = u;
        tick();
        start = 1'b0;
        clear = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check_eq("step.S", controlS, i);
            check_eq("step.C", controlC, exp_c[i]);
            check_eq("step.Z", controlZ, exp_z[i]);
            check_eq("step.busy", busy, 1);
            check_eq("step.done", done, 0);
            tick();
        end
        check_eq("upd.done", done, 1);
        check_eq("upd.S", controlS, 0);
        check_eq("upd.C", controlC, 0);
        check_eq("upd.Z", controlZ, 3'd2);
        check_eq("upd.busy", busy, 1);
        tick();
        check_eq("post.done", done, 0);
        check_eq("post.busy", busy, 0);
        if (scripted) model_req(u);
    endtask

    task automatic clear_only();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr.busy", busy, 0);
        m_fk = 0; m_fk1 = 0; m_fk2 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dones, idles, misplaced;
        longint w, w1, w2, ac1, ac2, ac3, y;
        logic [23:0] u;

        ka1 = sx17(32'h847A);
        ka2 = sx17(32'h1FD0EC);
        kb0 = sx17(32'h4CE3);
        kb1 = sx17(32'hFB3246);
        kb2 = sx17(32'h4CE3);
        for (int i = 0; i < 8; i++) mac_tab[i] = '0;
        start = 0; clear = 0; u_in = 0;

        // Reset state
        do_reset();
        check_idle_out("rst");
        check_words("rst");

        // Scripted request
        mac_tab[1] = 24'h11; mac_tab[2] = 24'h22; mac_tab[3] = 24'h33;
        mac_tab[4] = 24'h44; mac_tab[5] = 24'h55;
        run_req(24'h000100, 1'b0, 1'b1);
        check_words("req1");

        // Second request, then clear keeps yk
        mac_tab[2] = 24'h66;
        run_req(24'h000200, 1'b0, 1'b1);
        check_words("req2");
        clear_only();
        check_words("clr");

        // Continuous start: one accept every 7 cycles
        mac_tab[2] = 24'h77;
        start = 1'b1;
        u_in  = 24'h000300;
        dones = 0; idles = 0; misplaced = 0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 21) start = 1'b0;
            if (done) dones++;
            if (!busy) begin
                idles++;
                if (k % 7 != 0) misplaced++;
            end
        end
        check_eq("cont.dones", dones, 3);
        check_eq("cont.idles", idles, 3);
        check_eq("cont.misplaced", misplaced, 0);
        for (int r = 0; r < 3; r++) model_req(24'h000300);
        check_words("cont");

        // start+clear together: history kept
        mac_tab[2] = 24'h88;
        run_req(24'h000400, 1'b1, 1'b1);
        check_words("startclr");

        // Reset during S3 acts without a clock edge
        start = 1'b1;
        u_in  = 24'h000500;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("s3.S", controlS, 3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_idle_out("midrst");
        check_words("midrst");
        tick();
        reset = 1'b0;
        tick();
        check_eq("midrst.after.done", done, 0);

        // Closed-loop impulse response against the filter recursion
        do_reset();
        closed = 1'b1;
        w1 = 0; w2 = 0;
        for (int n = 0; n < 16; n++) begin
            u = (n == 0) ? 24'h008000 : 24'h0;
            run_req(u, 1'b0, 1'b0);
            ac1 = sx24(longint'(u) + ((ka1 * w1) >>> 15));
            w   = sx24(ac1 + ((ka2 * w2) >>> 15));
            ac2 = sx24((kb0 * w) >>> 15);
            ac3 = sx24(ac2 + ((kb1 * w1) >>> 15));
            y   = sx24(ac3 + ((kb2 * w2) >>> 15));
            w2 = w1;
            w1 = w;
            check_eq("iir.yk", yk, 32'(y[23:0]));
            check_eq("iir.fk1", fk1, 32'(w[23:0]));
        end
        closed = 1'b0;

        // Randomized transactions
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            for (int i = 1; i <= 5; i++) mac_tab[i] = 24'($urandom);
            u = 24'($urandom);
            case (op)
                0: run_req(u, 1'b0, 1'b1);
                1: run_req(u, 1'b1, 1'b1);
                2: clear_only();
                default: begin
                    tick();
                    check_eq("rnd.idle.busy", busy, 0);
                end
            endcase
            check_words("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
